// File: rtl/servant_ptimer.sv
// Memory-mapped machine timer: MTIME/MTIMECMP with prescaler, auto-reload and
// a sticky match flag that drives a level interrupt when enabled.
module servant_ptimer #(
    parameter int unsigned RESET_ENABLE = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [1:0]  i_wb_adr,
    input  logic [31:0] i_wb_dat,
    input  logic        i_wb_we,
    input  logic        i_wb_cyc,
    output logic [31:0] o_wb_rdt,
    output logic        o_irq
);

    localparam logic [1:0] ADR_MTIME    = 2'd0;
    localparam logic [1:0] ADR_MTIMECMP = 2'd1;
    localparam logic [1:0] ADR_CTRL     = 2'd2;
    localparam logic [1:0] ADR_STATUS   = 2'd3;

    logic [31:0] mtime_q, mtime_d;
    logic [31:0] mtimecmp_q, mtimecmp_d;
    logic        en_q, en_d;
    logic        ie_q, ie_d;
    logic        ar_q, ar_d;
    logic [7:0]  pre_q, pre_d;
    logic [7:0]  pcnt_q, pcnt_d;
    logic        pend_q, pend_d;

    logic wr;
    logic tick;
    logic match;

    assign wr    = i_wb_cyc & i_wb_we;
    assign tick  = en_q && (pcnt_q == pre_q);
    // Match uses pre-write MTIME/MTIMECMP so same-edge bus writes never mask it.
    assign match = (mtime_q == mtimecmp_q);

    always_comb begin
        mtime_d    = mtime_q;
        mtimecmp_d = mtimecmp_q;
        en_d       = en_q;
        ie_d       = ie_q;
        ar_d       = ar_q;
        pre_d      = pre_q;
        pcnt_d     = pcnt_q;
        pend_d     = pend_q;

        if (!en_q || tick) begin
            pcnt_d = 8'd0;
        end else begin
            pcnt_d = pcnt_q + 8'd1;
        end

        if (tick) begin
            mtime_d = (match && ar_q) ? 32'd0 : mtime_q + 32'd1;
        end

        if (wr) begin
            case (i_wb_adr)
                ADR_MTIME:    mtime_d    = i_wb_dat;
                ADR_MTIMECMP: mtimecmp_d = i_wb_dat;
                ADR_CTRL: begin
                    en_d   = i_wb_dat[0];
                    ie_d   = i_wb_dat[1];
                    ar_d   = i_wb_dat[2];
                    pre_d  = i_wb_dat[15:8];
                    pcnt_d = 8'd0;
                end
                ADR_STATUS: begin
                    if (i_wb_dat[0]) begin
                        pend_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end

        // A new match outranks a same-edge clear.
        if (tick && match) begin
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            mtime_q    <= 32'd0;
            mtimecmp_q <= 32'hFFFF_FFFF;
            en_q       <= (RESET_ENABLE != 0);
            ie_q       <= 1'b0;
            ar_q       <= 1'b0;
            pre_q      <= 8'd0;
            pcnt_q     <= 8'd0;
            pend_q     <= 1'b0;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            en_q       <= en_d;
            ie_q       <= ie_d;
            ar_q       <= ar_d;
            pre_q      <= pre_d;
            pcnt_q     <= pcnt_d;
            pend_q     <= pend_d;
        end
    end

    always_comb begin
        o_wb_rdt = 32'd0;
        if (i_wb_cyc) begin
            case (i_wb_adr)
                ADR_MTIME:    o_wb_rdt = mtime_q;
                ADR_MTIMECMP: o_wb_rdt = mtimecmp_q;
                ADR_CTRL:     o_wb_rdt = {16'd0, pre_q, 5'd0, ar_q, ie_q, en_q};
                ADR_STATUS:   o_wb_rdt = {31'd0, pend_q};
                default:      o_wb_rdt = 32'd0;
            endcase
        end
    end

    assign o_irq = pend_q & ie_q;

endmodule

// File: tb/tb_servant_ptimer.sv
// Self-checking bench for servant_ptimer: directed scenarios followed by
// randomized bus traffic checked against a countdown-based behavioural model.
module tb_servant_ptimer;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [1:0]  i_wb_adr = 2'd0;
    logic [31:0] i_wb_dat = 32'd0;
    logic        i_wb_we = 1'b0;
    logic        i_wb_cyc = 1'b0;
    logic [31:0] o_wb_rdt;
    logic        o_irq;

    int n_cmp = 0;
    int n_fail = 0;

    servant_ptimer #(.RESET_ENABLE(1)) dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_wb_adr (i_wb_adr),
        .i_wb_dat (i_wb_dat),
        .i_wb_we  (i_wb_we),
        .i_wb_cyc (i_wb_cyc),
        .o_wb_rdt (o_wb_rdt),
        .o_irq    (o_irq)
    );

    always #5 i_clk = ~i_clk;

    // Behavioural model: m_cd counts cycles remaining until the next tick.
    logic [31:0] m_mtime, m_cmp;
    logic        m_en, m_ie, m_ar, m_pend;
    logic [7:0]  m_pre;
    int          m_cd;

    task automatic model_reset();
        m_mtime = 32'd0;
        m_cmp   = 32'hFFFF_FFFF;
        m_en    = 1'b1;
        m_ie    = 1'b0;
        m_ar    = 1'b0;
        m_pre   = 8'd0;
        m_cd    = 0;
        m_pend  = 1'b0;
    endtask

    function automatic logic [31:0] model_read(input logic [1:0] adr, input logic cyc);
        if (!cyc) return 32'd0;
        case (adr)
            2'd0:    return m_mtime;
            2'd1:    return m_cmp;
            2'd2:    return {16'd0, m_pre, 5'd0, m_ar, m_ie, m_en};
            default: return {31'd0, m_pend};
        endcase
    endfunction

    task automatic model_update(input logic [1:0] adr, input logic [31:0] dat,
                                input logic we, input logic cyc, input logic rst);
        bit tick, hit, wr;
        logic [31:0] nxt;
        if (rst) begin
            model_reset();
            return;
        end
        wr   = cyc && we;
        tick = m_en && (m_cd == 0);
        hit  = (m_mtime == m_cmp);
        nxt  = m_mtime;
        if (tick) nxt = (hit && m_ar) ? 32'd0 : m_mtime + 32'd1;
        if (wr && adr == 2'd0) nxt = dat;
        if (wr && adr == 2'd3 && dat[0]) m_pend = 1'b0;
        if (tick && hit) m_pend = 1'b1;
        if (wr && adr == 2'd1) m_cmp = dat;
        if (wr && adr == 2'd2) begin
            m_en  = dat[0];
            m_ie  = dat[1];
            m_ar  = dat[2];
            m_pre = dat[15:8];
            m_cd  = int'(dat[15:8]);
        end else if (!m_en || tick) begin
            m_cd = int'(m_pre);
        end else begin
            m_cd = m_cd - 1;
        end
        m_mtime = nxt;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // One bus cycle: drive, check combinational read, clock, check irq.
    task automatic step(input logic [1:0] adr, input logic [31:0] dat,
                        input logic we, input logic cyc, input logic rst);
        i_wb_adr = adr;
        i_wb_dat = dat;
        i_wb_we  = we;
        i_wb_cyc = cyc;
        i_rst    = rst;
        #1;
        chk("rdt", o_wb_rdt, model_read(adr, cyc));
        @(posedge i_clk);
        model_update(adr, dat, we, cyc, rst);
        #1;
        chk("irq", {31'd0, o_irq}, {31'd0, m_pend & m_ie});
        $display("step adr=%0d dat=%08h we=%0b cyc=%0b rst=%0b -> irq=%0b", adr, dat, we, cyc, rst, o_irq);
        i_wb_cyc = 1'b0;
        i_wb_we  = 1'b0;
        i_rst    = 1'b0;
    endtask

    task automatic wr_reg(input logic [1:0] adr, input logic [31:0] dat);
        step(adr, dat, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(2'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Mid-cycle read compared against a bench constant.
    task automatic peek(input string tag, input logic [1:0] adr, input logic [31:0] exp);
        i_wb_adr = adr;
        i_wb_cyc = 1'b1;
        i_wb_we  = 1'b0;
        #1;
        chk(tag, o_wb_rdt, exp);
        i_wb_cyc = 1'b0;
        #0;
    endtask

    initial begin
        model_reset();
        @(posedge i_clk);
        #1;
        // Reset state
        step(2'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        step(2'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        peek("rst_mtime", 2'd0, 32'd0);
        peek("rst_cmp", 2'd1, 32'hFFFF_FFFF);
        peek("rst_ctrl", 2'd2, 32'd1);
        peek("rst_status", 2'd3, 32'd0);
        chk("rst_irq", {31'd0, o_irq}, 32'd0);

        // Free-running count with PRE=0
        idle(10);
        peek("run10_mtime", 2'd0, 32'd10);
        chk("run10_irq", {31'd0, o_irq}, 32'd0);

        // PRE=3: write edge still ticks (old PRE=0), then every 4th cycle
        wr_reg(2'd2, 32'h0000_0301);
        peek("pre3_start", 2'd0, 32'd11);
        idle(3);
        peek("pre3_3cyc", 2'd0, 32'd11);
        idle(1);
        peek("pre3_4cyc", 2'd0, 32'd12);
        idle(8);
        peek("pre3_12cyc", 2'd0, 32'd14);

        // Auto-reload match and interrupt
        wr_reg(2'd2, 32'd0);
        wr_reg(2'd0, 32'd0);
        wr_reg(2'd1, 32'd5);
        wr_reg(2'd2, 32'h07);
        idle(5);
        peek("ar_mtime5", 2'd0, 32'd5);
        chk("ar_irq_pre", {31'd0, o_irq}, 32'd0);
        idle(1);
        chk("ar_irq_set", {31'd0, o_irq}, 32'd1);
        peek("ar_reload", 2'd0, 32'd0);
        wr_reg(2'd3, 32'd1);
        chk("ar_irq_clr", {31'd0, o_irq}, 32'd0);
        idle(4);
        chk("ar_irq_wait", {31'd0, o_irq}, 32'd0);
        idle(1);
        chk("ar_irq_again", {31'd0, o_irq}, 32'd1);

        // 32-bit wrap without flag, then match at zero
        wr_reg(2'd2, 32'd0);
        wr_reg(2'd3, 32'd1);
        wr_reg(2'd0, 32'hFFFF_FFFE);
        wr_reg(2'd1, 32'd0);
        wr_reg(2'd2, 32'd1);
        peek("wrap_fe", 2'd0, 32'hFFFF_FFFE);
        idle(1);
        peek("wrap_ff", 2'd0, 32'hFFFF_FFFF);
        idle(1);
        peek("wrap_0", 2'd0, 32'd0);
        peek("wrap_nopend", 2'd3, 32'd0);
        idle(1);
        peek("wrap_pend", 2'd3, 32'd1);
        peek("wrap_mtime1", 2'd0, 32'd1);

        // Same-edge collisions
        wr_reg(2'd2, 32'd0);
        wr_reg(2'd3, 32'd1);
        wr_reg(2'd0, 32'd3);
        wr_reg(2'd1, 32'd3);
        wr_reg(2'd2, 32'd1);
        wr_reg(2'd3, 32'd1);
        peek("clr_vs_set", 2'd3, 32'd1);
        wr_reg(2'd0, 32'h100);
        peek("wr_vs_tick", 2'd0, 32'h100);
        wr_reg(2'd3, 32'd1);
        peek("mtime_101", 2'd0, 32'h101);
        wr_reg(2'd1, 32'h102);
        peek("cmp_old", 2'd3, 32'd0);
        peek("cmp_new", 2'd1, 32'h102);

        // Reset mid-count with pending flag and concurrent write
        wr_reg(2'd2, 32'd0);
        wr_reg(2'd0, 32'd2);
        wr_reg(2'd1, 32'd2);
        wr_reg(2'd2, 32'h0307);
        idle(4);
        chk("prerst_irq", {31'd0, o_irq}, 32'd1);
        idle(2);
        step(2'd1, 32'h55, 1'b1, 1'b1, 1'b1);
        chk("rst2_irq", {31'd0, o_irq}, 32'd0);
        peek("rst2_mtime", 2'd0, 32'd0);
        peek("rst2_cmp", 2'd1, 32'hFFFF_FFFF);
        peek("rst2_ctrl", 2'd2, 32'd1);
        peek("rst2_status", 2'd3, 32'd0);
        idle(1);
        peek("rst2_pcnt", 2'd0, 32'd1);

        // Randomized traffic against the model
        for (int n = 0; n < 2000; n++) begin
            logic [1:0]  adr;
            logic [31:0] dat;
            logic        cyc, we, rst;
            adr = 2'($urandom_range(0, 3));
            cyc = ($urandom_range(0, 9) < 4);
            we  = ($urandom_range(0, 1) == 1);
            rst = ($urandom_range(0, 299) == 0);
            dat = $urandom;
            case (adr)
                2'd0: if ($urandom_range(0, 3) != 0) dat = 32'($urandom_range(0, 12));
                2'd1: if ($urandom_range(0, 3) != 0) dat = 32'($urandom_range(0, 12));
                2'd2: dat[15:8] = 8'($urandom_range(0, 3));
                default: ;
            endcase
            if ($urandom_range(0, 19) == 0) dat[0] = 1'b0;
            step(adr, dat, we, cyc, rst);
        end
        peek("end_mtime", 2'd0, m_mtime);
        peek("end_cmp", 2'd1, m_cmp);
        peek("end_ctrl", 2'd2, {16'd0, m_pre, 5'd0, m_ar, m_ie, m_en});
        peek("end_status", 2'd3, {31'd0, m_pend});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/servant_ptimer.md
SERVANT_PTIMER -- requirements
Module: servant_ptimer

Interface
REQ-001 Parameter: RESET_ENABLE, default 1, value of CTRL.EN after reset.
REQ-002 i_clk  input  1  clock; all state updates on rising edge.
REQ-003 i_rst  input  1  reset, synchronous, active-high.
REQ-004 i_wb_adr  input  2  register word index (CPU address bits [3:2]).
REQ-005 i_wb_dat  input  32  write data from bus mux.
REQ-006 i_wb_we  input  1  write enable, qualified by i_wb_cyc.
REQ-007 i_wb_cyc  input  1  cycle strobe, already decoded for the timer region by the mux.
REQ-008 o_wb_rdt  output  32  read data; no ack output, the mux generates ack.
REQ-009 o_irq  output  1  level timer interrupt to CPU.

Function
REQ-010 Register map: 0 = MTIME (RW), 1 = MTIMECMP (RW), 2 = CTRL (RW), 3 = STATUS (R, W1C).
REQ-011 CTRL fields: bit0 EN, bit1 IE, bit2 AR (auto-reload), bits[15:8] PRE; all other bits ignored on write, read 0.
REQ-012 STATUS: bit0 PEND (sticky match flag); bits[31:1] read 0.
REQ-013 Writes take effect on every edge where i_wb_cyc & i_wb_we; all writes idempotent, so the mux's two-cycle cyc is harmless.
REQ-014 Writes are full 32-bit; no byte selects.
REQ-015 o_wb_rdt combinational from i_wb_adr and current register state; valid whenever i_wb_cyc is high, 0 otherwise.
REQ-016 Prescaler: 8-bit counter PCNT; when EN=1, PCNT increments each cycle; when PCNT==PRE, a one-cycle tick fires and PCNT returns to 0.
REQ-017 Tick period = PRE+1 cycles; PRE=0 gives tick every cycle.
REQ-018 EN=0: PCNT held at 0, no ticks, MTIME frozen, PEND unchanged.
REQ-019 Any write to CTRL clears PCNT to 0 that edge.
REQ-020 On tick with MTIME==MTIMECMP: PEND set to 1; MTIME loads 0 if AR=1, else MTIME+1.
REQ-021 On tick without match: MTIME <= MTIME+1, modulo 2^32 (0xFFFFFFFF wraps to 0, no flag).
REQ-022 o_irq = PEND & IE, combinational from registered state.
REQ-023 STATUS write with bit0=1 clears PEND; bit0=0 no effect.
REQ-024 Simultaneous MTIME write and tick: write wins, no increment that edge; match still evaluated against pre-write MTIME.
REQ-025 Simultaneous PEND clear and new match set: set wins, PEND=1.
REQ-026 MTIMECMP write same edge as tick: match compares old MTIMECMP.
REQ-027 Writes to STATUS other than bit0 and to read-only bits ignored.

Reset
REQ-028 On i_rst: MTIME=0, MTIMECMP=0xFFFFFFFF, EN=RESET_ENABLE, IE=0, AR=0, PRE=0, PCNT=0, PEND=0.
REQ-029 During reset o_irq=0; reset mid-count discards PCNT and PEND; reset overrides any concurrent bus write.

Verification
REQ-030 Reset, EN=1, PRE=0, run 10 cycles -> MTIME reads 10, o_irq=0.
REQ-031 Write CTRL=0x0000_0301 (PRE=3, EN=1), run 12 cycles -> MTIME advanced by 3, ticks every 4th cycle.
REQ-032 MTIMECMP=5, CTRL=0x07 (EN,IE,AR) -> PEND and o_irq rise on tick where MTIME==5, MTIME then 0; write STATUS=1 -> o_irq=0 next cycle; re-asserts after 6 further ticks.
REQ-033 MTIME=0xFFFF_FFFE, MTIMECMP=0, AR=0, PRE=0 -> reads 0xFFFF_FFFF, 0, then PEND=1 on next tick (MTIME==0), MTIME=1.
REQ-034 Same-edge PEND clear and match -> PEND stays 1; same-edge MTIME write 0x100 and tick -> MTIME=0x100.
REQ-035 i_rst asserted with PEND=1, PCNT mid-count, concurrent write -> all REQ-028 values next cycle, o_irq=0.
